// File: rtl/clk_step_pkg.sv
`default_nettype none
// ============================================================================
//  clk_step_pkg : shared command/state encodings for the clock step controller
//  Revision     : 1.0
// ============================================================================
package clk_step_pkg;

  localparam int c_op_w = 2;
  localparam int c_st_w = 2;

  typedef enum logic [c_op_w-1:0] {
    OP_HALT = 2'd0,
    OP_RUN  = 2'd1,
    OP_STEP = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [c_st_w-1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2
  } st_e;

  function automatic logic st_is_active(input st_e st);
    return st != ST_HALTED;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_gate_cell.sv
`default_nettype none
// ============================================================================
//  clk_gate_cell : latch-based integrated clock gate with scan bypass
//  Revision      : 1.0
// ============================================================================
module clk_gate_cell (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic r_en_lat;

  // Transparent only while clk_i is low so enable changes never cut a high phase;
  // the async clear kills an in-flight pulse the moment reset asserts.
  always_latch begin
    if (!rst_ni) begin
      r_en_lat <= 1'b0;
    end else if (!clk_i) begin
      r_en_lat <= en_i;
    end
  end

  assign clk_o = clk_i & (r_en_lat | test_en_i);

endmodule
`default_nettype wire

// File: rtl/clk_step_ctrl.sv
`default_nettype none
// ============================================================================
//  clk_step_ctrl : multi-channel debug clock halt / run / N-step controller
//  Revision      : 1.0
// ============================================================================
module clk_step_ctrl
  import clk_step_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [1:0]              cmd_op_i,
  input  logic [NUM_CH-1:0]       cmd_ch_mask_i,
  input  logic [CNT_W-1:0]        cmd_count_i,
  input  logic                    abort_i,
  input  logic                    test_en_i,
  output logic [NUM_CH-1:0]       clk_o,
  output logic [2*NUM_CH-1:0]     state_o,
  output logic [CNT_W*NUM_CH-1:0] remaining_o,
  output logic [NUM_CH-1:0]       done_o,
  output logic                    aborted_o
);

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic [NUM_CH-1:0] w_stepping;
  logic [NUM_CH-1:0] w_active;
  logic              w_accept;
  logic              w_count_zero;
  op_e               w_op;
  logic              r_aborted;

  // Stepping channels block new commands so a step count is never disturbed mid-run.
  assign cmd_ready_o  = ~abort_i & ~(|w_stepping);
  assign w_accept     = cmd_valid_i & cmd_ready_o;
  assign w_op         = op_e'(cmd_op_i);
  assign w_count_zero = (cmd_count_i == '0);

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      st_e              r_state;
      logic             r_en_q;
      logic [CNT_W-1:0] r_remaining;
      logic             r_done;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_state     <= ST_HALTED;
          r_en_q      <= 1'b0;
          r_remaining <= '0;
          r_done      <= 1'b0;
        end else begin
          r_done <= 1'b0;
          if (abort_i) begin
            if (st_is_active(r_state)) begin
              r_state     <= ST_HALTED;
              r_en_q      <= 1'b0;
              r_remaining <= '0;
            end
          end else if (w_accept && cmd_ch_mask_i[c]) begin
            case (w_op)
              OP_HALT: begin
                r_state     <= ST_HALTED;
                r_en_q      <= 1'b0;
                r_remaining <= '0;
              end
              OP_RUN: begin
                r_state <= ST_RUNNING;
                r_en_q  <= 1'b1;
              end
              OP_STEP: begin
                if (w_count_zero) begin
                  r_state     <= ST_HALTED;
                  r_en_q      <= 1'b0;
                  r_remaining <= '0;
                  r_done      <= 1'b1;
                end else begin
                  r_state     <= ST_STEPPING;
                  r_en_q      <= 1'b1;
                  r_remaining <= cmd_count_i;
                end
              end
              default: ;
            endcase
          end else if (r_state == ST_STEPPING) begin
            // Enable drops at the edge of the last pulse; the latch keeps that pulse whole.
            if (r_remaining == c_cnt_one) begin
              r_state     <= ST_HALTED;
              r_en_q      <= 1'b0;
              r_remaining <= '0;
              r_done      <= 1'b1;
            end else begin
              r_remaining <= r_remaining - c_cnt_one;
            end
          end
        end
      end

      assign w_stepping[c]                  = (r_state == ST_STEPPING);
      assign w_active[c]                    = st_is_active(r_state);
      assign state_o[2*c +: 2]              = r_state;
      assign remaining_o[CNT_W*c +: CNT_W]  = r_remaining;
      assign done_o[c]                      = r_done;

      clk_gate_cell u_gate (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en_i      (r_en_q),
        .test_en_i (test_en_i),
        .clk_o     (clk_o[c])
      );
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= abort_i & (|w_active);
    end
  end

  assign aborted_o = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_clk_step_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_clk_step_ctrl : directed self-checking bench for clk_step_ctrl
//  Revision         : 1.0
// ============================================================================
module tb_clk_step_ctrl;
  import clk_step_pkg::*;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;

  logic                    clk;
  logic                    rst_n;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [1:0]              cmd_op;
  logic [NUM_CH-1:0]       cmd_mask;
  logic [CNT_W-1:0]        cmd_count;
  logic                    abort;
  logic                    test_en;
  logic [NUM_CH-1:0]       gclk;
  logic [2*NUM_CH-1:0]     state;
  logic [CNT_W*NUM_CH-1:0] remaining;
  logic [NUM_CH-1:0]       done;
  logic                    aborted;

  int checks = 0;
  int errors = 0;
  int pc0 = 0;
  int pc1 = 0;
  int bad_w = 0;

  clk_step_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_op_i      (cmd_op),
    .cmd_ch_mask_i (cmd_mask),
    .cmd_count_i   (cmd_count),
    .abort_i       (abort),
    .test_en_i     (test_en),
    .clk_o         (gclk),
    .state_o       (state),
    .remaining_o   (remaining),
    .done_o        (done),
    .aborted_o     (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge gclk[0]) pc0++;
  always @(posedge gclk[1]) pc1++;

  // Every gated high phase must equal the 5-unit high phase of clk.
  always begin : g_w0
    time t;
    @(posedge gclk[0]); t = $time;
    @(negedge gclk[0]);
    if ($time - t != 5) bad_w++;
  end
  always begin : g_w1
    time t;
    @(posedge gclk[1]); t = $time;
    @(negedge gclk[1]);
    if ($time - t != 5) bad_w++;
  end

  function automatic int pcnt(input int ch);
    return (ch == 0) ? pc0 : pc1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [NUM_CH-1:0] mask, input logic [CNT_W-1:0] cnt);
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_count = cnt;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Step one channel by n and check pulse-by-pulse timing, countdown, ready and done.
  task automatic run_step(input int ch, input int n);
    int p0;
    logic [NUM_CH-1:0] dmask;
    dmask = NUM_CH'(1) << ch;
    p0 = pcnt(ch);
    chk("step_ready_before", cmd_ready, 1'b1);
    send(OP_STEP, dmask, CNT_W'(n));
    if (n == 0) begin
      chk("step0_state", state[2*ch +: 2], ST_HALTED);
      chk("step0_done", done, dmask);
      chk("step0_clk", gclk, '0);
    end else begin
      chk("step_state", state[2*ch +: 2], ST_STEPPING);
      chk("step_rem_load", remaining[CNT_W*ch +: CNT_W], n);
      chk("step_ready_low", cmd_ready, 1'b0);
      chk("step_clk_k", gclk[ch], 1'b0);
      for (int i = 1; i <= n; i++) begin
        tick();
        chk("step_pulse", gclk[ch], 1'b1);
        chk("step_other_clk", gclk[1-ch], 1'b0);
        if (i < n) begin
          chk("step_rem", remaining[CNT_W*ch +: CNT_W], n - i);
          chk("step_ready", cmd_ready, 1'b0);
          chk("step_done_early", done, '0);
        end else begin
          chk("step_rem_end", remaining[CNT_W*ch +: CNT_W], 0);
          chk("step_done", done, dmask);
          chk("step_ready_end", cmd_ready, 1'b1);
          chk("step_state_end", state[2*ch +: 2], ST_HALTED);
        end
      end
    end
    tick();
    chk("step_after_clk", gclk[ch], 1'b0);
    chk("step_after_done", done, '0);
    chk("step_pulse_count", pcnt(ch) - p0, n);
  endtask

  initial begin
    int p0, p1;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_mask = '0; cmd_count = '0;
    abort = 1'b0; test_en = 1'b0;

    // T1 reset with clock running
    repeat (3) tick();
    chk("rst_clk", gclk, '0);
    chk("rst_state", state, '0);
    chk("rst_rem", remaining, '0);
    chk("rst_done", done, '0);
    chk("rst_aborted", aborted, 1'b0);
    @(negedge clk); #2; rst_n = 1'b1;
    tick();
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_clk_after", gclk, '0);

    // T2 / T3 stepping and boundaries
    run_step(0, 5);
    run_step(0, 1);
    run_step(0, 0);
    run_step(1, 3);
    run_step(0, 255);

    // reserved op and empty mask are no-ops
    send(OP_RSVD, 2'b11, 8'd4);
    chk("rsvd_state", state, '0);
    send(OP_STEP, 2'b00, 8'd4);
    chk("mask0_state", state, '0);
    chk("mask0_ready", cmd_ready, 1'b1);

    // T4 run both, halt ch0 only
    send(OP_RUN, 2'b11, 8'd0);
    chk("run_state", state, {ST_RUNNING, ST_RUNNING});
    repeat (3) tick();
    chk("run_clk", gclk, 2'b11);
    send(OP_HALT, 2'b01, 8'd0);
    chk("halt_state", state, {ST_RUNNING, ST_HALTED});
    chk("halt_last_pulse", gclk, 2'b11);
    p0 = pc0; p1 = pc1;
    repeat (4) tick();
    chk("halt_ch0_stopped", pc0 - p0, 0);
    chk("halt_ch1_runs", pc1 - p1, 4);
    chk("glitch_free", bad_w, 0);
    send(OP_HALT, 2'b10, 8'd0);
    tick();
    chk("halt_all_state", state, '0);
    chk("halt_all_clk", gclk, '0);

    // T5 abort during ch1 step at pulse 4
    p0 = pc0; p1 = pc1;
    send(OP_STEP, 2'b10, 8'd10);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("abort_pre_pulse", gclk[1], 1'b1);
    end
    abort = 1'b1;
    cmd_op = OP_RUN; cmd_mask = 2'b01; cmd_valid = 1'b1;
    #1;
    chk("abort_ready", cmd_ready, 1'b0);
    tick();
    chk("abort_pulse4", gclk[1], 1'b1);
    chk("abort_flag", aborted, 1'b1);
    chk("abort_state", state, '0);
    chk("abort_rem", remaining, '0);
    chk("abort_no_done", done, '0);
    chk("abort_ready_idle", cmd_ready, 1'b0);
    tick();
    chk("abort_cmd_blocked", state, '0);
    chk("abort_flag_clear", aborted, 1'b0);
    abort = 1'b0; cmd_valid = 1'b0;
    tick();
    chk("abort_pulse_count", pc1 - p1, 4);
    chk("abort_ch0_count", pc0 - p0, 0);
    chk("abort_done_after", done, '0);

    // T6 reset mid-pulse, then scan bypass
    send(OP_STEP, 2'b01, 8'd10);
    tick();
    tick();
    chk("midrst_high", gclk[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_fall", gclk[0], 1'b0);
    chk("midrst_state", state, '0);
    chk("midrst_rem", remaining, '0);
    @(negedge clk); #2; rst_n = 1'b1;
    test_en = 1'b1;
    tick();
    chk("scan_high", gclk, 2'b11);
    chk("scan_state", state, '0);
    @(negedge clk); #1;
    chk("scan_low", gclk, 2'b00);
    tick();
    send(OP_STEP, 2'b10, 8'd2);
    chk("scan_step_state", state[3:2], ST_STEPPING);
    tick();
    tick();
    chk("scan_step_done", done, 2'b10);
    chk("scan_clk_still", gclk, 2'b11);
    test_en = 1'b0;
    tick();
    chk("scan_off_clk", gclk, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
